// File: rtl/mdu_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter_if
// Brief    : Request/result bundle between the EX stage and the iterative
//            multiply/divide unit.
// Revision : 1.0  initial release
// ============================================================================
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic             annul_i;
  logic             stallreq_o;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             dbz_o;

  // The unit itself
  modport slave (
    input  start_i, op_i, opa_i, opb_i, annul_i,
    output stallreq_o, busy_o, valid_o, hi_o, lo_o, dbz_o
  );

  // The pipeline side issuing operations
  modport master (
    output start_i, op_i, opa_i, opb_i, annul_i,
    input  stallreq_o, busy_o, valid_o, hi_o, lo_o, dbz_o
  );
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Brief    : Shared iterative multiply/divide unit producing MIPS-style
//            {hi, lo} results. Shift-add multiply, restoring divide, one
//            bit per cycle on magnitudes with a sign fix-up at the end.
//            Optional macro MDU_MUL_EARLY_OUT_EN lets multiplies finish as
//            soon as the remaining multiplier bits are all zero.
// Revision : 1.0  initial release
// ============================================================================
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave bus_io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sign_q, sign_d;       // quotient / product sign
  logic             sign_r_q, sign_r_d;   // remainder sign (dividend sign)
  logic [WIDTH-1:0] acc_q, acc_d;         // MUL upper accumulator / DIV remainder
  logic [WIDTH-1:0] sr_q, sr_d;           // MUL multiplier+low product / DIV dividend+quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
`ifdef MDU_MUL_EARLY_OUT_EN
  localparam int CNT_X = CNT_W + 1;
  logic [WIDTH-1:0] mrem_q, mrem_d;       // multiplier bits not yet consumed
  logic [CNT_W:0]   w_align;
`endif

  // Operand magnitudes; only signed ops take the absolute value
  logic             w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;

  assign w_neg_a = bus_io.op_i[0] & bus_io.opa_i[WIDTH-1];
  assign w_neg_b = bus_io.op_i[0] & bus_io.opb_i[WIDTH-1];
  assign w_abs_a = w_neg_a ? (-bus_io.opa_i) : bus_io.opa_i;
  assign w_abs_b = w_neg_b ? (-bus_io.opb_i) : bus_io.opb_i;

  // One multiply step: conditional add, then shift {carry, acc, sr} right
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul_acc, w_mul_sr;

  assign w_addend  = sr_q[0] ? opnd_q : '0;
  assign w_sum     = {1'b0, acc_q} + {1'b0, w_addend};
  assign w_mul_acc = w_sum[WIDTH:1];
  assign w_mul_sr  = {w_sum[0], sr_q[WIDTH-1:1]};

  // One restoring divide step: shift {rem, quo} left, trial subtract
  logic [WIDTH:0]   w_shift, w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_acc, w_div_sr;

  assign w_shift   = {acc_q, sr_q[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, opnd_q});
  assign w_trial   = w_shift - {1'b0, opnd_q};
  assign w_div_acc = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_div_sr  = {sr_q[WIDTH-2:0], w_ge};

  logic [WIDTH-1:0] w_it_acc, w_it_sr;
  assign w_it_acc = op_q[1] ? w_div_acc : w_mul_acc;
  assign w_it_sr  = op_q[1] ? w_div_sr  : w_mul_sr;

  // Final-iteration detection and product alignment
  logic               w_last;
  logic [2*WIDTH-1:0] w_prod, w_prod_al, w_mul_res;

  assign w_prod = {w_it_acc, w_it_sr};
`ifdef MDU_MUL_EARLY_OUT_EN
  // Remaining multiplier after this step is mrem_q >> 1; once it is zero the
  // rest of the iterations would only shift, so do that shift in one go.
  assign w_last    = (cnt_q == C_LAST) | (~op_q[1] & (mrem_q[WIDTH-1:1] == '0));
  assign w_align   = CNT_X'(WIDTH) - ({1'b0, cnt_q} + CNT_X'(1));
  assign w_prod_al = w_prod >> w_align;
`else
  assign w_last    = (cnt_q == C_LAST);
  assign w_prod_al = w_prod;
`endif

  // Sign fix-up of the magnitude results
  logic [WIDTH-1:0] w_quo_fix, w_rem_fix;

  assign w_mul_res = (op_q[0] & sign_q)   ? (-w_prod_al) : w_prod_al;
  assign w_quo_fix = (op_q[0] & sign_q)   ? (-w_it_sr)   : w_it_sr;
  assign w_rem_fix = (op_q[0] & sign_r_q) ? (-w_it_acc)  : w_it_acc;

  logic w_stallreq;

  // Next-state, datapath update and stall request
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sign_d     = sign_q;
    sign_r_d   = sign_r_q;
    acc_d      = acc_q;
    sr_d       = sr_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;
`ifdef MDU_MUL_EARLY_OUT_EN
    mrem_d     = mrem_q;
`endif
    w_stallreq = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus_io.start_i && !bus_io.annul_i) begin
          w_stallreq = 1'b1;
          op_d       = bus_io.op_i;
          sign_d     = w_neg_a ^ w_neg_b;
          sign_r_d   = w_neg_a;
          cnt_d      = '0;
          if (bus_io.op_i[1] && (bus_io.opb_i == '0)) begin
            // Divide by zero completes immediately with the raw dividend in hi
            state_d = S_DONE;
            hi_d    = bus_io.opa_i;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            acc_d   = '0;
            if (bus_io.op_i[1]) begin
              sr_d   = w_abs_a;
              opnd_d = w_abs_b;
            end else begin
              sr_d   = w_abs_b;
              opnd_d = w_abs_a;
            end
`ifdef MDU_MUL_EARLY_OUT_EN
            mrem_d  = w_abs_b;
`endif
          end
        end
      end

      S_CALC: begin
        if (bus_io.annul_i) begin
          state_d = S_IDLE;
        end else begin
          w_stallreq = 1'b1;
          acc_d      = w_it_acc;
          sr_d       = w_it_sr;
          cnt_d      = cnt_q + CNT_W'(1);
`ifdef MDU_MUL_EARLY_OUT_EN
          mrem_d     = mrem_q >> 1;
`endif
          if (w_last) begin
            state_d = S_DONE;
            dbz_d   = 1'b0;
            if (op_q[1]) begin
              hi_d = w_rem_fix;
              lo_d = w_quo_fix;
            end else begin
              hi_d = w_mul_res[2*WIDTH-1:WIDTH];
              lo_d = w_mul_res[WIDTH-1:0];
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      sign_r_q <= 1'b0;
      acc_q    <= '0;
      sr_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
`ifdef MDU_MUL_EARLY_OUT_EN
      mrem_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      sign_r_q <= sign_r_d;
      acc_q    <= acc_d;
      sr_q     <= sr_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
`ifdef MDU_MUL_EARLY_OUT_EN
      mrem_q   <= mrem_d;
`endif
    end
  end

  assign bus_io.stallreq_o = w_stallreq;
  assign bus_io.busy_o     = (state_q == S_CALC) || (state_q == S_DONE);
  assign bus_io.valid_o    = (state_q == S_DONE);
  assign bus_io.hi_o       = hi_q;
  assign bus_io.lo_o       = lo_q;
  assign bus_io.dbz_o      = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Self-checking bench for mdu_iter: directed cases plus random
//            operations against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_iter;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(WIDTH)) bus ();

  mdu_iter #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic
  function automatic logic [63:0] exp_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: return {32'd0, a} * {32'd0, b};
      2'b01: begin
        p = sa * sb;
        return p;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Reference latency from the accepting cycle to the valid cycle
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MDU_MUL_EARLY_OUT_EN
    logic [31:0] ab;
    int          msb;
`endif
    if (op[1] && b == 32'd0) return 1;
`ifdef MDU_MUL_EARLY_OUT_EN
    if (!op[1]) begin
      ab  = (op[0] && b[31]) ? (-b) : b;
      msb = 0;
      for (int i = 0; i < 32; i++) if (ab[i]) msb = i;
      return msb + 2;
    end
`endif
    return WIDTH + 1;
  endfunction

  // Issue one operation now and follow it to completion
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [63:0] e;
    int          lat;
    int          c;
    logic        stall_ok;
    logic        seen;
    e   = exp_res(op, a, b);
    lat = exp_lat(op, b);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.opa_i   = a;
    bus.opb_i   = b;
    bus.annul_i = 1'b0;
    #1;
    stall_ok = (bus.stallreq_o === 1'b1);
    c    = 0;
    seen = 1'b0;
    while (!seen && c < 200) begin
      @(posedge clk); #1;
      c++;
      bus.start_i = 1'b0;
      bus.op_i    = 2'($urandom);
      bus.opa_i   = $urandom;
      bus.opb_i   = $urandom;
      #1;
      if (bus.valid_o === 1'b1) seen = 1'b1;
      else if (bus.stallreq_o !== 1'b1 || bus.busy_o !== 1'b1) stall_ok = 1'b0;
    end
    check({tag, "_lat"}, 64'(c), 64'(lat));
    check({tag, "_stall_win"}, {63'd0, stall_ok}, 64'd1);
    check({tag, "_stall_done"}, {63'd0, bus.stallreq_o}, 64'd0);
    check({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, e);
    check({tag, "_dbz"}, {63'd0, bus.dbz_o}, {63'd0, (op[1] && b == 32'd0)});
    @(posedge clk); #2;
    check({tag, "_pulse"}, {62'd0, bus.valid_o, bus.busy_o}, 64'd0);
    check({tag, "_hold"}, {bus.hi_o, bus.lo_o}, e);
  endtask

  logic [31:0] corner [5] = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 15));
      default: return corner[$urandom_range(0, 4)];
    endcase
  endfunction

  initial begin
    logic [31:0] prev_hi, prev_lo;
    logic        prev_dbz, seen_v;
    logic [63:0] e;
    int          c;

    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.opa_i   = '0;
    bus.opb_i   = '0;
    bus.annul_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    check("rst_flags", {60'd0, bus.valid_o, bus.busy_o, bus.dbz_o, bus.stallreq_o}, 64'd0);

    @(posedge clk); #1;
    do_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5);
    do_op("divu_100_7", 2'b10, 32'd100, 32'd7);
    do_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2);
    do_op("div_dbz", 2'b11, 32'h1234_5678, 32'd0);
    do_op("divu_9_3", 2'b10, 32'd9, 32'd3);

    // Annul in the middle of a multiply
    prev_hi  = bus.hi_o;
    prev_lo  = bus.lo_o;
    prev_dbz = bus.dbz_o;
    bus.start_i = 1'b1;
    bus.op_i    = 2'b00;
    bus.opa_i   = 32'd6;
    bus.opb_i   = 32'd7;
    seen_v = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      bus.annul_i = (k == 10);
      #1;
      if (bus.valid_o === 1'b1) seen_v = 1'b1;
      if (k == 10) check("annul_stall", {63'd0, bus.stallreq_o}, 64'd0);
      if (k == 11) check("annul_idle", {63'd0, bus.busy_o}, 64'd0);
    end
    check("annul_novalid", {63'd0, seen_v}, 64'd0);
    check("annul_keep", {31'd0, bus.dbz_o, bus.hi_o, bus.lo_o}, {31'd0, prev_dbz, prev_hi, prev_lo});
    @(posedge clk); #1;
    do_op("annul_restart", 2'b00, 32'd6, 32'd7);

    // Reset in the middle of a divide, with non-zero outputs beforehand
    do_op("divu_dbz", 2'b10, 32'd55, 32'd0);
    bus.start_i = 1'b1;
    bus.op_i    = 2'b11;
    bus.opa_i   = 32'd1000;
    bus.opb_i   = 32'd3;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      if (k == 5) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    check("midrst_flags", {60'd0, bus.valid_o, bus.busy_o, bus.dbz_o, bus.stallreq_o}, 64'd0);
    @(posedge clk); #1;
    do_op("after_rst", 2'b10, 32'd1000, 32'd3);

    // start_i held through DONE: ignored there, accepted the next IDLE cycle
    bus.start_i = 1'b1;
    bus.op_i    = 2'b10;
    bus.opa_i   = 32'd50;
    bus.opb_i   = 32'd6;
    c = 0;
    seen_v = 1'b0;
    while (!seen_v && c < 200) begin
      @(posedge clk); #2;
      c++;
      if (bus.valid_o === 1'b1) seen_v = 1'b1;
    end
    check("held_lat", 64'(c), 64'(WIDTH + 1));
    check("held_hilo", {bus.hi_o, bus.lo_o}, exp_res(2'b10, 32'd50, 32'd6));
    bus.op_i  = 2'b00;
    bus.opa_i = 32'd11;
    bus.opb_i = 32'd13;
    @(posedge clk); #2;
    check("held_idle", {62'd0, bus.busy_o, bus.stallreq_o}, 64'd1);
    do_op("held_next", 2'b00, 32'd11, 32'd13);

    do_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("multu_5x3", 2'b00, 32'd5, 32'd3);

    // Random operations against the reference model
    for (int n = 0; n < 24; n++) begin
      do_op($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), pick(), pick());
    end

    e = 64'd0;
    if (e != 64'd0) $display("unreachable");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage.
- Replaces the separate mul and div instances with one shared datapath.
- Supports signed and unsigned MULT and DIV, and produces MIPS-style {hi, lo} results.
- Drives a stall request to the pipeline control while busy, and accepts an annul (flush) mid-operation.

Parameters:
- WIDTH, 32, operand width in bits; hi_o and lo_o are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request a new operation; sampled only in IDLE.
- op_i  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- opa_i  in  WIDTH  multiplicand / dividend.
- opb_i  in  WIDTH  multiplier / divisor.
- annul_i  in  1  abort current operation (pipeline flush).
- stallreq_o  out  1  combinational stall request to pipeline control.
- busy_o  out  1  high in CALC and DONE.
- valid_o  out  1  one-cycle pulse; hi_o and lo_o are updated this cycle.
- hi_o  out  WIDTH  MUL: product[2W-1:W]; DIV: remainder.
- lo_o  out  WIDTH  MUL: product[W-1:0]; DIV: quotient.
- dbz_o  out  1  divide-by-zero flag; updated with valid_o, held until next completion.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE.
  - valid_o=0, busy_o=0, hi_o=0, lo_o=0, dbz_o=0; counter and internal registers 0.
  - rst dominates start_i and annul_i, and aborts any operation in flight.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and annul_i=0:
    - Latch op_i.
    - Latch absolute values of the operands (signed ops only), plus sign_q = signA^signB and sign_r = signA.
    - Counter = 0.
    - Go to CALC.
  - DIV/DIVU with opb_i==0: go directly to DONE with the dbz path.
  - start_i=0, or annul_i=1: stay in IDLE.
- CALC, MUL (shift-add):
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the upper accumulator.
  - Then shift {acc, multiplier} right by 1, keeping the carry.
  - WIDTH iterations.
- CALC, DIV (restoring):
  - Each cycle: shift {rem, quo} left by 1, trial-subtract the divisor from rem.
  - If the trial result is non-negative, rem = difference and quo LSB = 1.
  - WIDTH iterations.
- CALC exit: counter reaches WIDTH-1 → DONE.
- annul_i=1 in CALC: next state IDLE; no valid_o; hi_o, lo_o and dbz_o unchanged.
- DONE:
  - valid_o=1 for exactly this cycle.
  - hi_o and lo_o registered on entry to DONE, with sign fix-up applied:
    - Signed MUL: negate the 2W product if sign_q=1.
    - Signed DIV: negate the quotient if sign_q=1; negate the remainder if sign_r=1.
  - Next state is always IDLE; start_i is ignored in DONE.
  - annul_i in DONE has no effect.
- Latency: start accepted at cycle 0 → valid_o at cycle WIDTH+1 (33 for WIDTH=32).
- Divide-by-zero path:
  - valid_o at cycle 1.
  - lo_o = all ones, hi_o = opa_i unmodified, dbz_o=1.
  - dbz_o is cleared on any other completion.
- Signed overflow: DIV of -2^(W-1) by -1 gives lo_o = 0x80000000 (wraps) and hi_o = 0. No flag.
- stallreq_o = (state==IDLE & start_i & ~annul_i) | (state==CALC & ~annul_i).
  - Low in DONE, so the instruction advances the cycle valid_o fires.
- Holding: hi_o and lo_o hold their values between completions.
- Operand changes: changes on opa_i, opb_i and op_i after acceptance are ignored.

Optional Feature:
- Macro: MDU_MUL_EARLY_OUT_EN.
- Defined:
  - MUL leaves CALC once the remaining multiplier shift register is zero (checked after each iteration).
  - At least one CALC cycle is always spent.
  - The accumulator is aligned by one final shift of (WIDTH - iterations done) before DONE.
  - Latency = msb_index(|opb|)+2 cycles; opb=0 counts as msb_index 0.
  - DIV latency is unchanged.
- Undefined: MUL always takes WIDTH iterations; no early-exit logic or barrel shift is synthesised.

Test Plan:
- MULT opa=0xFFFFFFFD (-3), opb=5 → valid_o at cycle 33; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1; stallreq_o high in cycles 0–32, low in cycle 33.
- DIVU opa=100, opb=7 → lo_o=14, hi_o=2, dbz_o=0 at cycle 33. DIV opa=-7, opb=2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIV opa=0x12345678, opb=0 → valid_o at cycle 1; lo_o=0xFFFFFFFF, hi_o=0x12345678, dbz_o=1. A following DIVU 9/3 → lo_o=3, hi_o=0, dbz_o=0.
- MULTU 6*7, annul_i at cycle 10 → no valid_o; stallreq_o=0 from cycle 10; hi_o/lo_o keep their previous values. A new start at cycle 12 → valid_o at cycle 45 with the correct product.
- rst asserted at cycle 5 of a DIV → all outputs 0 next cycle, state IDLE. start_i held during DONE → ignored, and the op is accepted the following IDLE cycle. Signed DIV 0x80000000 / 0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- With MDU_MUL_EARLY_OUT_EN: MULTU 5*3 → valid_o at cycle 3, lo_o=15, hi_o=0. Without the macro: valid_o at cycle 33, same values.
